// File: rtl/fac_bus_pkg.sv
// Shared definitions for the factorial-core bus master: bus widths, register
// offsets within the core's block, and the job sequencer state encoding.
package fac_bus_pkg;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 32;

  localparam logic [ADDR_W-1:0] OFS_OPERAND  = 8'h00;
  localparam logic [ADDR_W-1:0] OFS_INTR_EN  = 8'h01;
  localparam logic [ADDR_W-1:0] OFS_OPSTART  = 8'h03;
  localparam logic [ADDR_W-1:0] OFS_INTR_CLR = 8'h04;
  localparam logic [ADDR_W-1:0] OFS_RESULT_H = 8'h05;
  localparam logic [ADDR_W-1:0] OFS_RESULT_L = 8'h06;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_REQ1,
    ST_W_OP,
    ST_W_IEN,
    ST_W_START,
    ST_WAIT_INT,
    ST_REQ2,
    ST_R_H,
    ST_R_L,
    ST_W_CLR,
    ST_DONE
  } fac_state_e;

endpackage

// File: rtl/fac_timeout_cnt.sv
// Wait-cycle counter for bus masters: counts enabled cycles from a clear and
// flags the enabled cycle in which the count reaches LIMIT-1.
module fac_timeout_cnt #(
  parameter int LIMIT = 4096
) (
  input  logic clk,
  input  logic reset_n,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expire
);

  localparam int CNT_W = (LIMIT > 1) ? $clog2(LIMIT) : 1;

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (!reset_n || i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_expire = i_en && (r_cnt == CNT_W'(LIMIT - 1));

endmodule

// File: rtl/fac_bus_master.sv
// Bus initiator that runs one factorial job on the factorial core: program,
// start, release the bus, wait for the interrupt, read the result, clear.
module fac_bus_master
  import fac_bus_pkg::*;
#(
  parameter int                TIMEOUT  = 4096,
  parameter logic [ADDR_W-1:0] FAC_BASE = 8'h20
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                cmd_start,
  input  logic [DATA_W-1:0]   cmd_operand,
  output logic                cmd_busy,
  output logic                cmd_done,
  output logic                cmd_err,
  output logic [2*DATA_W-1:0] result,
  output logic                M_req,
  output logic                M_wr,
  output logic [ADDR_W-1:0]   M_address,
  output logic [DATA_W-1:0]   M_dout,
  input  logic                M_grant,
  input  logic [DATA_W-1:0]   M_din,
  input  logic                f_interrupt
);

  fac_state_e          r_state;
  fac_state_e          w_next;
  logic [DATA_W-1:0]   r_operand;
  logic [2*DATA_W-1:0] r_result;
  logic                r_err;
  logic                r_pend;
  logic                r_pend_hi;

  logic                w_req;
  logic                w_wr_cmd;
  logic                w_rd;
  logic                w_accept;
  logic                w_set_err;
  logic                w_expire;
  logic [ADDR_W-1:0]   w_addr;
  logic [DATA_W-1:0]   w_dout;

  fac_timeout_cnt #(
    .LIMIT(TIMEOUT)
  ) u_timeout (
    .clk     (clk),
    .reset_n (reset_n),
    .i_clr   (r_state != ST_WAIT_INT),
    .i_en    (r_state == ST_WAIT_INT),
    .o_expire(w_expire)
  );

  // Every bus state holds until granted; a write is only driven while granted.
  always_comb begin
    w_next    = r_state;
    w_req     = 1'b0;
    w_wr_cmd  = 1'b0;
    w_addr    = '0;
    w_dout    = '0;
    w_rd      = 1'b0;
    w_accept  = 1'b0;
    w_set_err = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (cmd_start) begin
          w_accept = 1'b1;
          w_next   = ST_REQ1;
        end
      end
      ST_REQ1: begin
        w_req = 1'b1;
        if (M_grant) w_next = ST_W_OP;
      end
      ST_W_OP: begin
        w_req    = 1'b1;
        w_wr_cmd = 1'b1;
        w_addr   = FAC_BASE + OFS_OPERAND;
        w_dout   = r_operand;
        if (M_grant) w_next = ST_W_IEN;
      end
      ST_W_IEN: begin
        w_req    = 1'b1;
        w_wr_cmd = 1'b1;
        w_addr   = FAC_BASE + OFS_INTR_EN;
        w_dout   = DATA_W'(1);
        if (M_grant) w_next = ST_W_START;
      end
      ST_W_START: begin
        w_req    = 1'b1;
        w_wr_cmd = 1'b1;
        w_addr   = FAC_BASE + OFS_OPSTART;
        w_dout   = DATA_W'(1);
        if (M_grant) w_next = ST_WAIT_INT;
      end
      ST_WAIT_INT: begin
        // The interrupt takes priority over a timeout in the same cycle.
        if (f_interrupt) begin
          w_next = ST_REQ2;
        end else if (w_expire) begin
          w_next    = ST_REQ2;
          w_set_err = 1'b1;
        end
      end
      ST_REQ2: begin
        w_req = 1'b1;
        if (M_grant) w_next = r_err ? ST_W_CLR : ST_R_H;
      end
      ST_R_H: begin
        w_req  = 1'b1;
        w_addr = FAC_BASE + OFS_RESULT_H;
        if (M_grant) begin
          w_rd   = 1'b1;
          w_next = ST_R_L;
        end
      end
      ST_R_L: begin
        w_req  = 1'b1;
        w_addr = FAC_BASE + OFS_RESULT_L;
        if (M_grant) begin
          w_rd   = 1'b1;
          w_next = ST_W_CLR;
        end
      end
      ST_W_CLR: begin
        w_req    = 1'b1;
        w_wr_cmd = 1'b1;
        w_addr   = FAC_BASE + OFS_INTR_CLR;
        w_dout   = DATA_W'(1);
        if (M_grant) w_next = ST_DONE;
      end
      ST_DONE: w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  // Read data arrives the cycle after a granted read, whatever the grant is then.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state   <= ST_IDLE;
      r_err     <= 1'b0;
      r_pend    <= 1'b0;
      r_pend_hi <= 1'b0;
      r_result  <= '0;
    end else begin
      r_state   <= w_next;
      r_pend    <= w_rd;
      r_pend_hi <= (r_state == ST_R_H);
      if (w_accept) begin
        r_err <= 1'b0;
      end else if (w_set_err) begin
        r_err <= 1'b1;
      end
      if (r_pend) begin
        if (r_pend_hi) begin
          r_result[2*DATA_W-1:DATA_W] <= M_din;
        end else begin
          r_result[DATA_W-1:0] <= M_din;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_accept) r_operand <= cmd_operand;
  end

  assign M_req     = w_req;
  assign M_wr      = w_wr_cmd & M_grant;
  assign M_address = w_addr;
  assign M_dout    = w_dout;
  assign cmd_busy  = (r_state != ST_IDLE);
  assign cmd_done  = (r_state == ST_DONE);
  assign cmd_err   = (r_state == ST_DONE) & r_err;
  assign result    = r_result;

endmodule

// File: tb/tb_fac_bus_master.sv
// Bench for fac_bus_master: a register-level factorial core on the bus, random
// grant patterns and interrupt delays, and a per-job reference of bus traffic.
module tb_fac_bus_master;

  localparam int          TMO   = 16;
  localparam logic [7:0]  A_OP  = 8'h20;
  localparam logic [7:0]  A_IEN = 8'h21;
  localparam logic [7:0]  A_ST  = 8'h23;
  localparam logic [7:0]  A_CLR = 8'h24;
  localparam logic [7:0]  A_RH  = 8'h25;
  localparam logic [7:0]  A_RL  = 8'h26;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        cmd_start = 1'b0;
  logic [31:0] cmd_operand = '0;
  logic        cmd_busy, cmd_done, cmd_err;
  logic [63:0] result;
  logic        M_req, M_wr;
  logic [7:0]  M_address;
  logic [31:0] M_dout;
  logic        M_grant = 1'b1;
  logic [31:0] M_din = '0;
  logic        f_interrupt = 1'b0;

  int n_chk = 0;
  int n_err = 0;

  fac_bus_master #(.TIMEOUT(TMO), .FAC_BASE(8'h20)) dut (
    .clk(clk), .reset_n(reset_n), .cmd_start(cmd_start), .cmd_operand(cmd_operand),
    .cmd_busy(cmd_busy), .cmd_done(cmd_done), .cmd_err(cmd_err), .result(result),
    .M_req(M_req), .M_wr(M_wr), .M_address(M_address), .M_dout(M_dout),
    .M_grant(M_grant), .M_din(M_din), .f_interrupt(f_interrupt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] fact(input logic [31:0] n);
    logic [63:0] p;
    p = 64'd1;
    for (int i = 2; i <= int'(n); i++) p = p * 64'(i);
    return p;
  endfunction

  // Bus samples taken mid-cycle; the core model acts on them at the next edge.
  logic       s_req = 1'b0, s_grant = 1'b0, s_wr = 1'b0;
  logic [7:0] s_addr = '0;
  logic [31:0] s_dout = '0;

  int c_busy = 0, c_wait = 0, c_int_wait = 0, c_stall = 0, c_wr_ng = 0, c_done = 0;
  logic        d_err = 1'b0;
  logic [63:0] d_result = '0;

  always @(negedge clk) begin
    s_req   = M_req;
    s_grant = M_grant;
    s_wr    = M_wr;
    s_addr  = M_address;
    s_dout  = M_dout;
    if (reset_n) begin
      if (cmd_busy) c_busy++;
      if (cmd_busy && !M_req && !cmd_done) begin
        c_wait++;
        if (f_interrupt) c_int_wait++;
      end
      if (M_req && !M_grant) c_stall++;
      if (M_wr && !M_grant) c_wr_ng++;
      if (cmd_done) begin
        c_done++;
        d_err    = cmd_err;
        d_result = result;
      end
    end
  end

  // Factorial core register model with a programmable interrupt delay.
  logic [40:0] log_q[$];
  int          irq_dly = 0;
  bit          no_irq = 1'b0;
  logic [31:0] m_op = '0;
  logic        m_ien = 1'b0, m_run = 1'b0;
  logic [63:0] m_res = '0;
  int          m_cnt = 0;

  always @(posedge clk) begin
    if (!reset_n) begin
      m_op <= '0; m_ien <= 1'b0; m_run <= 1'b0; m_res <= '0; m_cnt <= 0;
      f_interrupt <= 1'b0; M_din <= '0;
    end else begin
      if (m_run) begin
        if (m_cnt == 0) begin
          m_run <= 1'b0;
          if (!no_irq) f_interrupt <= m_ien;
        end else begin
          m_cnt <= m_cnt - 1;
        end
      end
      if (s_req && s_grant) begin
        if (s_wr) begin
          log_q.push_back({1'b1, s_addr, s_dout});
          if (s_addr == A_OP) m_op <= s_dout;
          else if (s_addr == A_IEN) m_ien <= s_dout[0];
          else if (s_addr == A_ST && s_dout[0]) begin
            m_res <= fact(m_op);
            m_run <= 1'b1;
            m_cnt <= irq_dly;
          end else if (s_addr == A_CLR && s_dout[0]) f_interrupt <= 1'b0;
        end else if (s_addr[7:4] == A_OP[7:4]) begin
          log_q.push_back({1'b0, s_addr, 32'h0});
          if (s_addr == A_RH) M_din <= m_res[63:32];
          else if (s_addr == A_RL) M_din <= m_res[31:0];
          else M_din <= 32'hDEADBEEF;
        end
      end
    end
  end

  // Grant driver: 0 = always granted, 1 = random, 2 = drop 3 cycles at W_IEN.
  int g_mode = 0;
  int g_drop = 0;
  bit g_dropped = 1'b0;

  always @(posedge clk) begin
    #1;
    if (g_mode != 2) g_dropped = 1'b0;
    if (g_mode == 2 && !g_dropped && s_req && s_grant && s_wr && s_addr == A_OP) begin
      g_drop    = 3;
      g_dropped = 1'b1;
    end
    if (g_drop > 0) begin
      M_grant = 1'b0;
      g_drop--;
    end else if (g_mode == 1) begin
      M_grant = ($urandom_range(0, 9) < 7);
    end else begin
      M_grant = 1'b1;
    end
  end

  task automatic chk_idle(input string tag);
    chk({tag, "_ctl"}, 64'({cmd_busy, cmd_done, cmd_err, M_req, M_wr}), 64'h0);
    chk({tag, "_bus"}, 64'({M_address, M_dout}), 64'h0);
    chk({tag, "_result"}, result, 64'h0);
  endtask

  task automatic run_job(input logic [31:0] op, input int dly, input bit nirq,
                         input int gmode, input bit pulse);
    int b_busy, b_wait, b_iw, b_stall, b_wng, b_done, b_log;
    bit seen, pulsed, exp_err;
    int exp_wait, exp_busy;
    logic [40:0] exp_q[$];
    repeat (2) @(posedge clk);
    #1;
    irq_dly = dly;
    no_irq  = nirq;
    g_mode  = gmode;
    b_busy = c_busy; b_wait = c_wait; b_iw = c_int_wait;
    b_stall = c_stall; b_wng = c_wr_ng; b_done = c_done; b_log = log_q.size();
    cmd_operand = op;
    cmd_start   = 1'b1;
    @(posedge clk);
    #1;
    cmd_start = 1'b0;
    seen   = 1'b0;
    pulsed = 1'b0;
    for (int c = 0; c < 200 && !seen; c++) begin
      @(negedge clk);
      if (cmd_done) seen = 1'b1;
      if (pulse && !pulsed && cmd_busy && !M_req && !cmd_done) begin
        cmd_start   = 1'b1;
        cmd_operand = op + 32'd3;
        pulsed      = 1'b1;
      end else begin
        cmd_start = 1'b0;
      end
    end
    cmd_start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    g_mode = 0;

    exp_err  = nirq || (dly + 2 > TMO);
    exp_wait = exp_err ? TMO : dly + 2;
    exp_busy = (exp_err ? 7 : 9) + exp_wait + (c_stall - b_stall);
    exp_q.push_back({1'b1, A_OP, op});
    exp_q.push_back({1'b1, A_IEN, 32'd1});
    exp_q.push_back({1'b1, A_ST, 32'd1});
    if (!exp_err) begin
      exp_q.push_back({1'b0, A_RH, 32'd0});
      exp_q.push_back({1'b0, A_RL, 32'd0});
    end
    exp_q.push_back({1'b1, A_CLR, 32'd1});

    chk("done_seen", 64'(seen), 64'd1);
    chk("done_pulses", 64'(c_done - b_done), 64'd1);
    chk("cmd_err", 64'(d_err), 64'(exp_err));
    if (!exp_err) chk("result", d_result, fact(op));
    chk("wait_cycles", 64'(c_wait - b_wait), 64'(exp_wait));
    chk("int_seen_in_wait", 64'(c_int_wait - b_iw), exp_err ? 64'd0 : 64'd1);
    chk("busy_cycles", 64'(c_busy - b_busy), 64'(exp_busy));
    chk("wr_without_grant", 64'(c_wr_ng - b_wng), 64'd0);
    if (gmode == 2) chk("stall_cycles", 64'(c_stall - b_stall), 64'd3);
    chk("bus_xfer_count", 64'(log_q.size() - b_log), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && b_log + i < log_q.size(); i++)
      chk($sformatf("bus_xfer_%0d", i), 64'(log_q[b_log + i]), 64'(exp_q[i]));
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit found;
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_idle("reset");
    @(posedge clk);
    #1;
    reset_n = 1'b1;

    run_job(32'd4, 3, 1'b0, 0, 1'b0);
    chk("op4_result", d_result, 64'h18);
    run_job(32'd10, 5, 1'b0, 0, 1'b0);
    chk("op10_result", d_result, 64'h375F00);
    run_job(32'd7, 2, 1'b0, 2, 1'b0);
    run_job(32'd5, 0, 1'b1, 0, 1'b0);
    run_job(32'd6, 5, 1'b0, 0, 1'b1);
    run_job(32'd12, 14, 1'b0, 0, 1'b0);
    run_job(32'd3, 13, 1'b0, 1, 1'b0);

    for (int k = 0; k < 8; k++)
      run_job(32'($urandom_range(0, 20)), int'($urandom_range(0, 14)),
              ($urandom_range(0, 4) == 0), int'($urandom_range(0, 1)), 1'b0);

    // Reset in the middle of the result read, then a clean job.
    @(posedge clk);
    #1;
    irq_dly     = 2;
    no_irq      = 1'b0;
    cmd_operand = 32'd9;
    cmd_start   = 1'b1;
    @(posedge clk);
    #1;
    cmd_start = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 100 && !found; c++) begin
      @(negedge clk);
      if (M_req && !M_wr && M_address == A_RL) found = 1'b1;
    end
    chk("reach_r_l", 64'(found), 64'd1);
    reset_n = 1'b0;
    @(negedge clk);
    chk_idle("mid_reset");
    reset_n = 1'b1;
    run_job(32'd8, 4, 1'b0, 0, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
